// File: rtl/mpu_pkg.sv
//------------------------------------------------------------------------------
// Module  : mpu_pkg
// Brief   : Shared MPU constants, operand-loader state encoding and element
//           offset helper used by the loader and the arithmetic stages.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mpu_pkg;

    localparam int ELEM_W   = 8;
    localparam int DIM      = 5;
    localparam int ELEMS    = DIM * DIM;
    localparam int MATRIX_W = ELEM_W * ELEMS;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Column index is the outer index: element (col,row) sits at k = row + DIM*col.
    function automatic int at(input int col, input int row);
        return ELEM_W * (row + DIM * col);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mpu_elem_counter.sv
//------------------------------------------------------------------------------
// Module  : mpu_elem_counter
// Brief   : Element index counter with clear, enable and last-element flag;
//           wraps to zero when advanced on the last element.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mpu_elem_counter
    import mpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    logic [CNT_W-1:0] r_count;

    assign o_count    = r_count;
    assign o_terminal = (r_count == CNT_W'(ELEMS - 1));

    // Clear wins over enable so an abort never lets a stray beat advance the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_terminal ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mpu_operand_loader.sv
//------------------------------------------------------------------------------
// Module  : mpu_operand_loader
// Brief   : Assembles streamed signed bytes into flattened 5x5 operands A
//           (and optionally B) and offers them on a valid/ready interface.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mpu_operand_loader
    import mpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                need_b,
    input  logic                abort,
    input  logic [ELEM_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [MATRIX_W-1:0] matrix_a,
    output logic [MATRIX_W-1:0] matrix_b,
    output logic                operands_valid,
    input  logic                operands_ready,
    output logic                busy
);

    state_t           r_state;
    logic             r_need_b;
    logic             w_accept;
    logic             w_cnt_clear;
    logic             w_terminal;
    logic [CNT_W-1:0] w_count;
    logic [7:0]       w_offset;

    // in_ready is only ever high in a load state, so no state qualifier is needed.
    assign w_accept    = in_valid & in_ready & ~abort;
    assign w_cnt_clear = abort | ((r_state == IDLE) & start);
    assign w_offset    = {w_count, 3'b000};

    mpu_elem_counter u_elem_counter (
        .clk        (clock),
        .rst        (reset),
        .i_clear    (w_cnt_clear),
        .i_enable   (w_accept),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_need_b       <= 1'b0;
            matrix_a       <= '0;
            matrix_b       <= '0;
            in_ready       <= 1'b0;
            operands_valid <= 1'b0;
            busy           <= 1'b0;
        end else if (abort) begin
            // Matrix contents are deliberately left as-is; they are not valid operands.
            r_state        <= IDLE;
            in_ready       <= 1'b0;
            operands_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= LOAD_A;
                        r_need_b <= need_b;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        if (!need_b) begin
                            matrix_b <= '0;
                        end
                    end
                end
                LOAD_A: begin
                    if (w_accept) begin
                        matrix_a[w_offset +: ELEM_W] <= in_data;
                        if (w_terminal) begin
                            if (r_need_b) begin
                                r_state <= LOAD_B;
                            end else begin
                                r_state        <= HOLD;
                                in_ready       <= 1'b0;
                                operands_valid <= 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        matrix_b[w_offset +: ELEM_W] <= in_data;
                        if (w_terminal) begin
                            r_state        <= HOLD;
                            in_ready       <= 1'b0;
                            operands_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (operands_ready) begin
                        r_state        <= IDLE;
                        operands_valid <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    in_ready       <= 1'b0;
                    operands_valid <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
